// File: rtl/zilla_adder_pkg.sv
// Shared definitions for the Zilla datapath serial adder: control states and slice width.
package zilla_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIB_BITS = 4;

endpackage

// File: rtl/carry_skip_4bit.sv
// 4-bit carry-skip adder slice: ripple chain plus a bypass when every bit propagates.
module carry_skip_4bit (
    input  logic [3:0] ain,
    input  logic [3:0] bin,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] prop;
    logic [3:0] gen;
    logic       c1, c2, c3, c4;

    assign prop = ain ^ bin;
    assign gen  = ain & bin;

    assign c1 = gen[0] | (prop[0] & cin);
    assign c2 = gen[1] | (prop[1] & c1);
    assign c3 = gen[2] | (prop[2] & c2);
    assign c4 = gen[3] | (prop[3] & c3);

    assign sum = prop ^ {c3, c2, c1, cin};

    // A fully propagating nibble forwards its carry-in without waiting on the ripple.
    assign cout = (&prop) ? cin : c4;

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder reusing one carry-skip slice, one nibble per clock, LSB first.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one nibble added per cycle, carry kept in carry_q
// DONE  | result presented with out_valid until out_ready
module nibble_serial_adder
    import zilla_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             zero,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIB_BITS;
    localparam int CNT_W = $clog2(NIB);

    if ((WIDTH % NIB_BITS) != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
    end

    state_e                state_q;
    logic [WIDTH-1:0]      a_sh_q;
    logic [WIDTH-1:0]      b_sh_q;
    logic [WIDTH-1:0]      sum_sh_q;
    logic                  carry_q;
    logic [CNT_W-1:0]      nib_cnt_q;
    logic [WIDTH-1:0]      sum_q;
    logic                  cout_q;
    logic                  zero_q;

    logic [NIB_BITS-1:0]   slice_sum;
    logic                  slice_cout;
    logic [WIDTH-1:0]      sum_sh_d;
    logic                  last_nib;

    carry_skip_4bit u_slice (
        .ain  (a_sh_q[NIB_BITS-1:0]),
        .bin  (b_sh_q[NIB_BITS-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign sum_sh_d = {slice_sum, sum_sh_q[WIDTH-1:NIB_BITS]};
    assign last_nib = (nib_cnt_q == CNT_W'(NIB - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            carry_q   <= 1'b0;
            nib_cnt_q <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            zero_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_q    <= ain;
                        b_sh_q    <= bin;
                        carry_q   <= cin;
                        nib_cnt_q <= '0;
                        sum_sh_q  <= '0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q   <= a_sh_q >> NIB_BITS;
                    b_sh_q   <= b_sh_q >> NIB_BITS;
                    sum_sh_q <= sum_sh_d;
                    carry_q  <= slice_cout;
                    if (last_nib) begin
                        // Output registers only move here, so the result persists past DONE.
                        nib_cnt_q <= '0;
                        sum_q     <= sum_sh_d;
                        cout_q    <= slice_cout;
                        zero_q    <= ~|sum_sh_d;
                        state_q   <= DONE;
                    end else begin
                        nib_cnt_q <= nib_cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder against a plain-arithmetic model of ain + bin + cin.
module tb_nibble_serial_adder;

    localparam int W   = 32;
    localparam int NIB = W / 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] ain;
    logic [W-1:0] bin;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         zero;
    logic         busy;

    int n_chk  = 0;
    int n_pass = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ain       (ain),
        .bin       (bin),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  in_ready,  1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_sum"},       sum,       0);
        chk({tag, "_cout"},      cout,      0);
        chk({tag, "_zero"},      zero,      1);
    endtask

    // Called at a negedge with the DUT expected idle; returns at a negedge after the result is taken.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input int stall, input bit noise);
        logic [W:0]   exp_full;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        int           lat;
        int           wait_cyc;

        exp_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        exp_sum  = exp_full[W-1:0];
        exp_cout = exp_full[W];

        wait_cyc = 0;
        while (!in_ready && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("accept_ready", in_ready, 1);

        ain      = a;
        bin      = b;
        cin      = c;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("run_busy", busy, 1);
        chk("run_in_ready", in_ready, 0);

        lat = 0;
        while (!out_valid && lat < 50) begin
            if (noise) begin
                in_valid = 1'($urandom);
                ain      = $urandom;
                bin      = $urandom;
                cin      = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, NIB);

        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            if (noise) begin
                in_valid = 1'($urandom);
                ain      = $urandom;
                bin      = $urandom;
            end
            chk("stall_sum", sum, exp_sum);
            chk("stall_valid", out_valid, 1);
            @(negedge clk);
        end

        chk("sum", sum, exp_sum);
        chk("cout", cout, exp_cout);
        chk("zero", zero, (exp_sum == '0));
        chk("out_valid", out_valid, 1);
        chk("done_in_ready", in_ready, 0);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("taken_out_valid", out_valid, 0);
        chk("taken_in_ready", in_ready, 1);
        chk("held_sum", sum, exp_sum);
        chk("held_cout", cout, exp_cout);
    endtask

    initial begin
        logic seen_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ain       = '0;
        bin       = '0;
        cin       = 1'b0;
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("post_reset");

        run_op(32'hAAAAAAAA, 32'h55555555, 1'b1, 0, 1'b0);
        run_op(32'hAAAAAAAA, 32'h55555555, 1'b0, 0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
        run_op(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 5, 1'b1);

        // Abort mid-RUN after three nibbles have been processed.
        ain      = 32'h12345678;
        bin      = 32'h11111111;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_vals("abort");
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 2 * NIB; i++) begin
            if (out_valid) seen_valid = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_valid", seen_valid, 0);
        chk_reset_vals("abort_idle");

        run_op(32'h00000001, 32'h00000002, 1'b0, 0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = ~ra;
            run_op(ra, rb, 1'($urandom), $urandom_range(0, 3), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
